// File: rtl/edp_mulseq.sv
// edp_mulseq: iterative W-bit signed multiply (radix-2 Booth) and divide (non-restoring)
// sequencer for the EBOX data path; one step per clock, 2W-bit result on {hi,lo}.
module edp_mulseq #(
  parameter int unsigned W  = 36,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_op,
  input  logic          i_abort,
  input  logic [0:W-1]  i_a,
  input  logic [0:W-1]  i_b_hi,
  input  logic [0:W-1]  i_b_lo,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_no_divide,
  output logic [0:W-1]  o_hi,
  output logic [0:W-1]  o_lo,
  output logic [0:CW-1] o_step_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e        r_state;
  logic          r_op;
  logic          r_bb;
  logic          r_busy;
  logic          r_done;
  logic          r_nd;
  logic          r_ndp;
  logic          r_sd;
  logic          r_sv;
  logic [0:W-1]  r_a;
  logic [0:W-1]  r_hi;
  logic [0:W-1]  r_lo;
  logic [0:CW-1] r_cnt;

  logic [0:2*W]  w_dmag;
  logic [0:2*W]  w_vlim;
  logic [0:W]    w_vmag;
  logic          w_nodiv;
  logic [0:W]    w_bsum;
  logic [0:W]    w_dsh;
  logic [0:W]    w_dnew;
  logic [0:W-1]  w_rem;
  logic [0:W-1]  w_rfin;
  logic [0:W-1]  w_quo;

  always_comb begin
    // Divide operands as magnitudes; a too-large dividend can never reach the negate overflow.
    w_dmag  = i_b_hi[0] ? (~{1'b1, i_b_hi, i_b_lo} + {{(2 * W){1'b0}}, 1'b1})
                        : {1'b0, i_b_hi, i_b_lo};
    w_vmag  = i_a[0] ? (~{1'b1, i_a} + {{W{1'b0}}, 1'b1}) : {1'b0, i_a};
    w_vlim  = {1'b0, w_vmag, {(W - 1){1'b0}}};
    w_nodiv = (w_dmag >= w_vlim);

    case ({r_lo[W-1], r_bb})
      2'b01:   w_bsum = {r_hi[0], r_hi} + {r_a[0], r_a};
      2'b10:   w_bsum = {r_hi[0], r_hi} - {r_a[0], r_a};
      default: w_bsum = {r_hi[0], r_hi};
    endcase

    // Partial remainder stays within (-|V|-1, |V|), so W bits hold it between steps.
    w_dsh  = {r_hi, r_lo[0]};
    w_dnew = r_hi[0] ? (w_dsh + {1'b0, r_a}) : (w_dsh - {1'b0, r_a});
    w_rem  = r_hi[0] ? (r_hi + r_a) : r_hi;
    w_rfin = r_sd ? -w_rem : w_rem;
    w_quo  = (r_sd ^ r_sv) ? -r_lo : r_lo;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_op    <= 1'b0;
      r_bb    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nd    <= 1'b0;
      r_ndp   <= 1'b0;
      r_sd    <= 1'b0;
      r_sv    <= 1'b0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start && !i_abort) begin
            r_busy <= 1'b1;
            r_nd   <= 1'b0;
            r_op   <= i_op;
            r_bb   <= 1'b0;
            r_sd   <= i_b_hi[0];
            r_sv   <= i_a[0];
            if (!i_op) begin
              r_a     <= i_a;
              r_hi    <= '0;
              r_lo    <= i_b_lo;
              r_ndp   <= 1'b0;
              r_cnt   <= CW'(W);
              r_state <= StRun;
            end else if (w_nodiv) begin
              // Rejected divide: dividend stays visible, completion on the next edge.
              r_a     <= i_a;
              r_hi    <= i_b_hi;
              r_lo    <= i_b_lo;
              r_ndp   <= 1'b1;
              r_cnt   <= '0;
              r_state <= StFix;
            end else begin
              r_a     <= w_vmag[1:W];
              r_hi    <= w_dmag[1:W];
              r_lo    <= w_dmag[W+1:2*W];
              r_ndp   <= 1'b0;
              r_cnt   <= CW'(W);
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_state <= StIdle;
          end else begin
            if (!r_op) begin
              r_hi <= w_bsum[0:W-1];
              r_lo <= {w_bsum[W], r_lo[0:W-2]};
              r_bb <= r_lo[W-1];
            end else begin
              r_hi <= w_dnew[1:W];
              r_lo <= {r_lo[1:W-1], ~w_dnew[0]};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              r_state <= StFix;
            end
          end
        end
        StFix: begin
          if (i_abort) begin
            r_hi <= '0;
            r_lo <= '0;
          end else begin
            if (r_ndp) begin
              r_nd <= 1'b1;
            end else if (r_op) begin
              r_hi <= w_rfin;
              r_lo <= w_quo;
            end
            r_done <= 1'b1;
          end
          r_ndp   <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_no_divide = r_nd;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_step_cnt  = r_cnt;

endmodule

// File: doc/edp_mulseq.md
Name: edp_mulseq

Overview:
- Parametrised iterative multiply/divide sequencer for the EBOX data path. Generalises the single-step AD/MQ shift path into an autonomous W-bit engine.
- Operands are captured on a start handshake. The engine runs one Booth or non-restoring step per clock, then reports a 2W-bit result with a done pulse.
- Sits beside the EDP adder; CTL drives start/op/abort, and results are loaded into AR/MQ by normal ARM/MQM selection.

Parameters:
- W, 36, operand width; bit 0 is the MSB of every vector; W >= 4.
- CW, $clog2(W+1), width of the step counter.

Ports:
- clk  in  1  EBOX data-path clock (CLK.EDP).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; honoured only in IDLE.
- op  in  1  0 = signed multiply, 1 = signed divide.
- abort  in  1  cancel operation in progress.
- a  in  W  multiplicand (MUL) or divisor (DIV).
- b_hi  in  W  dividend high word (DIV); ignored for MUL.
- b_lo  in  W  multiplier (MUL) or dividend low word (DIV).
- busy  out  1  operation in progress.
- done  out  1  one-clock completion pulse.
- no_divide  out  1  divide rejected; valid with done, held until next start.
- hi  out  W  product high word / remainder.
- lo  out  W  product low word / quotient.
- step_cnt  out  CW  remaining RUN steps.

Behaviour:
- Reset (async, reset_n low): state = IDLE; busy, done, no_divide, hi, lo and step_cnt are all 0. Reset mid-operation discards all work immediately.
- States are IDLE, RUN, FIX.
- IDLE:
  - start=1 and abort=0 at edge E0: capture a into the divisor/multiplicand register, and {b_hi,b_lo} (DIV) or {0,b_lo} (MUL) into the hi/lo working pair.
  - Set busy=1 and no_divide=0.
- MUL path:
  - step_cnt=W, then go to RUN.
  - Each RUN clock performs one radix-2 Booth step on lo[W-1] and the saved Booth bit.
  - The step adds, subtracts or skips `a` into hi, then arithmetically shifts {hi,lo} right 1.
  - step_cnt decrements; at 0 the state moves to FIX.
  - FIX is a no-op for MUL.
- DIV path:
  - Let D = signed {b_hi,b_lo} and V = signed a.
  - no_divide is declared iff V==0 or |D| >= |V|*2^(W-1).
  - On no_divide: skip RUN and FIX; after edge E1, done=1, busy=0, no_divide=1, and hi/lo keep the captured dividend unchanged.
  - Otherwise step_cnt=W and go to RUN: W non-restoring steps on magnitudes, one quotient bit per clock.
  - FIX performs remainder restore if negative, then sign correction.
  - Quotient truncates toward zero; remainder takes the dividend's sign (remainder 0 is 0).
  - Results: lo = quotient, hi = remainder.
- Timing for normal completion:
  - busy is high for exactly W+1 clocks.
  - FIX occupies the clock after edge E(W).
  - done=1 for exactly one clock after edge E(W+1), with busy=0 in that same clock.
- Outputs: hi/lo are registered, change only during RUN/FIX, and hold the result until the next accepted start.
- start while busy is ignored; no re-capture.
- abort:
  - In RUN or FIX, the next edge forces IDLE with busy=0, hi=lo=0 and step_cnt=0. No done pulse.
  - In IDLE, abort has no effect.
  - start and abort asserted together in IDLE: abort wins and nothing is captured.
- start asserted in the same clock done is high is accepted (back-to-back operations; the state is IDLE then).
- Arithmetic:
  - All adds are W+1 bits wide to hold the sign.
  - MUL result is the full two's-complement 2W-bit product, including (-2^(W-1))^2 = 2^(2W-2) with no overflow flag.
  - Operand registers are sampled only at the start edge; input changes afterwards are ignored.

Test Plan:
- W=36 MUL, a=3, b_lo=-5 -> hi=36'hFFFFFFFFF, lo=36'hFFFFFFFF1; busy high 37 clocks; done one clock after edge 37.
- W=36 MUL, a=b_lo=-2^35 -> hi=36'h400000000, lo=0.
- W=36 DIV:
  - D=100, V=7 -> lo=14, hi=2.
  - D=-100, V=7 -> lo=-14, hi=-2.
  - D=100, V=-7 -> lo=-14, hi=2.
  - no_divide=0 in all three.
- No-divide:
  - V=0, D=5 -> done after edge 1, no_divide=1, hi=b_hi, lo=b_lo.
  - D=2^35, V=1 -> no_divide=1.
- Control events:
  - abort asserted at step_cnt=20 -> busy=0 next clock, no done, hi=lo=0.
  - start pulsed mid-run -> ignored.
  - reset_n pulsed low mid-run -> all outputs 0 asynchronously.
- W=8 build: exhaustive signed MUL and 10k random DIV compared against a reference model; back-to-back starts coincident with done all complete.
